// File: rtl/mul_issue_ctrl_pkg.sv
// Shared definitions for the EXE-stage multiply issue controller:
// op encodings, FSM state encodings and the architectural result select.
package mul_issue_ctrl_pkg;

   localparam int MUL_OPC_W = 2;

   typedef enum logic [1:0] {
      MUL_OP_W   = 2'b00,
      MUL_OP_H   = 2'b01,
      MUL_OP_HU  = 2'b10,
      MUL_OP_RSV = 2'b11
   } mul_op_e;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_BUSY0 = 3'd1,
      ST_BUSY1 = 3'd2,
      ST_DONE  = 3'd3,
      ST_DRAIN = 3'd4
   } mul_state_e;

   // High half for mulh.w / mulh.wu; low half for mul.w and the reserved code.
   function automatic logic [31:0] mul_select(input logic [MUL_OPC_W-1:0] op,
                                              input logic [63:0]          prod);
      logic [31:0] res;
      case (op)
         MUL_OP_H,
         MUL_OP_HU: res = prod[63:32];
         default:   res = prod[31:0];
      endcase
      return res;
   endfunction

   // Only mulh.w needs a signed product; the low half is sign-agnostic.
   function automatic logic mul_is_signed(input logic [MUL_OPC_W-1:0] op);
      return (op == MUL_OP_H);
   endfunction

endpackage

// File: rtl/mul_issue_ctrl.sv
// EXE-stage sequencer for the two-cycle Booth/Wallace multiplier. Holds the
// request and operands stable, always ends a request on a complete cycle so
// the multiplier's internal counter stays aligned, and hands the selected
// 32-bit result to MEM through a valid/ready handshake.
module mul_issue_ctrl
   import mul_issue_ctrl_pkg::*;
#(
   parameter int TAG_W = 37
) (
   input  logic                 mul_clk,
   input  logic                 reset,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [MUL_OPC_W-1:0] in_op,
   input  logic [31:0]          in_x,
   input  logic [31:0]          in_y,
   input  logic [TAG_W-1:0]     in_tag,
   input  logic                 flush,
   output logic                 mul,
   output logic                 mul_signed,
   output logic [31:0]          mul_x,
   output logic [31:0]          mul_y,
   input  logic [63:0]          mul_result,
   input  logic                 mul_complete,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [31:0]          out_data,
   output logic [TAG_W-1:0]     out_tag
);

   mul_state_e           state_q, state_d;
   logic                 mul_q, out_valid_q, mul_signed_q;
   logic [31:0]          mul_x_q, mul_y_q, out_data_q;
   logic [TAG_W-1:0]     out_tag_q, tag_q;
   logic [MUL_OPC_W-1:0] op_q;
   logic                 accept, cap_res;

   assign accept = in_valid & in_ready;

   // Accept is only possible from IDLE or from DONE while MEM takes the result; flush always wins.
   always_comb begin
      in_ready = 1'b0;
      case (state_q)
         ST_IDLE: in_ready = ~flush;
         ST_DONE: in_ready = out_ready & ~flush;
         default: in_ready = 1'b0;
      endcase
   end

   // Next-state logic; a flush that leaves the counter mid-count routes through DRAIN.
   always_comb begin
      state_d = state_q;
      cap_res = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept) state_d = ST_BUSY0;
         end
         ST_BUSY0: begin
            state_d = flush ? ST_DRAIN : ST_BUSY1;
         end
         ST_BUSY1: begin
            if (mul_complete) begin
               if (flush) begin
                  state_d = ST_IDLE;
               end else begin
                  state_d = ST_DONE;
                  cap_res = 1'b1;
               end
            end else if (flush) begin
               // Counter still at 1: finish it without keeping the product.
               state_d = ST_DRAIN;
            end
         end
         ST_DONE: begin
            if (flush)          state_d = ST_IDLE;
            else if (out_ready) state_d = accept ? ST_BUSY0 : ST_IDLE;
         end
         ST_DRAIN: begin
            if (mul_complete) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // FSM state plus registered request/valid outputs decoded from the next state.
   always_ff @(posedge mul_clk) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         mul_q       <= 1'b0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         mul_q       <= (state_d == ST_BUSY0) || (state_d == ST_BUSY1) ||
                        (state_d == ST_DRAIN);
         out_valid_q <= (state_d == ST_DONE);
      end
   end

   // Multiplier operands change only on accept; result is captured only on a kept completion.
   always_ff @(posedge mul_clk) begin
      if (reset) begin
         mul_signed_q <= 1'b0;
         mul_x_q      <= '0;
         mul_y_q      <= '0;
         out_data_q   <= '0;
         out_tag_q    <= '0;
      end else begin
         if (accept) begin
            mul_signed_q <= mul_is_signed(in_op);
            mul_x_q      <= in_x;
            mul_y_q      <= in_y;
         end
         if (cap_res) begin
            out_data_q <= mul_select(op_q, mul_result);
            out_tag_q  <= tag_q;
         end
      end
   end

   // Op code and tag of the in-flight operation; only meaningful after an accept.
   always_ff @(posedge mul_clk) begin
      if (accept) begin
         op_q  <= in_op;
         tag_q <= in_tag;
      end
   end

   assign mul        = mul_q;
   assign mul_signed = mul_signed_q;
   assign mul_x      = mul_x_q;
   assign mul_y      = mul_y_q;
   assign out_valid  = out_valid_q;
   assign out_data   = out_data_q;
   assign out_tag    = out_tag_q;

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Bench for mul_issue_ctrl: a two-cycle multiplier model, a transaction-level
// reference of the controller checked every cycle, and directed literal cases.
module tb_mul_issue_ctrl;

   localparam int TAG_W = 37;

   logic             mul_clk = 1'b0;
   logic             reset;
   logic             in_valid;
   logic             in_ready;
   logic [1:0]       in_op;
   logic [31:0]      in_x, in_y;
   logic [TAG_W-1:0] in_tag;
   logic             flush;
   logic             mul, mul_signed;
   logic [31:0]      mul_x, mul_y;
   logic [63:0]      mul_result;
   logic             mul_complete;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      out_data;
   logic [TAG_W-1:0] out_tag;

   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   always #5 mul_clk = ~mul_clk;

   mul_issue_ctrl #(.TAG_W(TAG_W)) dut (
      .mul_clk(mul_clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
      .in_x(in_x), .in_y(in_y), .in_tag(in_tag), .flush(flush),
      .mul(mul), .mul_signed(mul_signed), .mul_x(mul_x), .mul_y(mul_y),
      .mul_result(mul_result), .mul_complete(mul_complete),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_tag(out_tag)
   );

   // Full 64-bit product, signed or unsigned.
   function automatic logic [63:0] mult(input logic s, input logic [31:0] a, input logic [31:0] b);
      longint pa, pb;
      pa = s ? longint'($signed(a)) : longint'({32'b0, a});
      pb = s ? longint'($signed(b)) : longint'({32'b0, b});
      return 64'(pa * pb);
   endfunction

   // Architectural result of one op, straight from the instruction semantics.
   function automatic logic [31:0] arch_result(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
      logic [63:0] p;
      p = mult(op == 2'b01, a, b);
      return (op == 2'b01 || op == 2'b10) ? p[63:32] : p[31:0];
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Multiplier model: counter advances while mul is high, completes on its 2nd cycle.
   logic [1:0]  mcnt;
   logic [63:0] junk;
   always @(posedge mul_clk) begin
      if (reset)    mcnt <= 2'd0;
      else if (mul) mcnt <= (mcnt == 2'd1) ? 2'd0 : mcnt + 2'd1;
      junk <= {$urandom, $urandom};
   end
   assign mul_complete = mul && (mcnt == 2'd1);
   assign mul_result   = mul_complete ? mult(mul_signed, mul_x, mul_y) : junk;

   // Reference: m_age = which multiply cycle the live op is in (0 none), m_drain =
   // a cancelled op still owes one cycle, m_hold = a result is waiting for MEM.
   int               m_age = 0;
   bit               m_drain = 0, m_hold = 0, m_sgn = 0;
   logic [1:0]       m_op = 0;
   logic [31:0]      m_x = 0, m_y = 0, m_data = 0;
   logic [TAG_W-1:0] m_tag = 0, m_otag = 0;

   function automatic bit exp_in_ready();
      return (m_age == 0) && !m_drain && (!m_hold || out_ready) && !flush;
   endfunction

   always @(posedge mul_clk) begin
      int               age;
      bit               drn, hold, sgn, acc;
      logic [1:0]       op;
      logic [31:0]      x, y, dat;
      logic [TAG_W-1:0] tg, otg;
      age = m_age; drn = m_drain; hold = m_hold; sgn = m_sgn; op = m_op;
      x = m_x; y = m_y; dat = m_data; tg = m_tag; otg = m_otag;
      if (reset) begin
         age = 0; drn = 0; hold = 0; sgn = 0; x = 0; y = 0; dat = 0; otg = 0;
      end else begin
         acc = in_valid && exp_in_ready();
         if (hold && (flush || out_ready)) hold = 0;
         if (drn) begin
            drn = 0;
         end else if (age == 1) begin
            if (flush) begin age = 0; drn = 1; end
            else age = 2;
         end else if (age == 2) begin
            age = 0;
            if (!flush) begin hold = 1; dat = arch_result(op, x, y); otg = tg; end
         end
         if (acc) begin
            age = 1; op = in_op; x = in_x; y = in_y; tg = in_tag; sgn = (in_op == 2'b01);
         end
      end
      m_age <= age; m_drain <= drn; m_hold <= hold; m_sgn <= sgn; m_op <= op;
      m_x <= x; m_y <= y; m_data <= dat; m_tag <= tg; m_otag <= otg;
   end

   // Per-cycle comparison, away from the active edge.
   always @(negedge mul_clk) begin
      if (chk_en) begin
         chk("in_ready",   in_ready,   exp_in_ready());
         chk("mul",        mul,        (m_age != 0) || m_drain);
         chk("mul_signed", mul_signed, m_sgn);
         chk("mul_x",      mul_x,      m_x);
         chk("mul_y",      mul_y,      m_y);
         chk("out_valid",  out_valid,  m_hold);
         chk("out_data",   out_data,   m_data);
         chk("out_tag",    out_tag,    m_otag);
      end
   end

   task automatic step();
      @(posedge mul_clk);
      #1;
   endtask

   task automatic present(input logic [1:0] op, input logic [31:0] x, input logic [31:0] y,
                          input logic [TAG_W-1:0] tag);
      in_valid = 1'b1; in_op = op; in_x = x; in_y = y; in_tag = tag;
      #1;
   endtask

   // Wait (bounded) for acceptance of the presented op, then take the accept edge.
   task automatic accept_now(input string name);
      int n;
      n = 0;
      while (!in_ready && n < 10) begin step(); n++; end
      chk(name, in_ready, 1'b1);
      step();
      in_valid = 1'b0;
      #1;
   endtask

   task automatic do_op(input string name, input logic [1:0] op, input logic [31:0] x,
                        input logic [31:0] y, input logic [TAG_W-1:0] tag,
                        input logic [31:0] expv, input logic exps);
      out_ready = 1'b1;
      present(op, x, y, tag);
      accept_now({name, "_acc"});
      chk({name, "_mul1"}, mul, 1'b1);
      chk({name, "_sgn"}, mul_signed, exps);
      step();
      chk({name, "_mul2"}, mul, 1'b1);
      chk({name, "_nov"}, out_valid, 1'b0);
      step();
      chk({name, "_vld"}, out_valid, 1'b1);
      chk({name, "_mul_off"}, mul, 1'b0);
      chk({name, "_data"}, out_data, expv);
      chk({name, "_tag"}, out_tag, tag);
      step();
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] corners [6];
      corners[0] = 32'h0; corners[1] = 32'h1; corners[2] = 32'hFFFFFFFF;
      corners[3] = 32'h80000000; corners[4] = 32'h7FFFFFFF; corners[5] = 32'hFFFFFFFE;

      reset = 1'b1; in_valid = 1'b0; in_op = 2'b00; in_x = '0; in_y = '0; in_tag = '0;
      flush = 1'b0; out_ready = 1'b1;
      step(); step();
      chk_en = 1'b1;
      chk("rst_mul", mul, 1'b0);
      chk("rst_mul_signed", mul_signed, 1'b0);
      chk("rst_mul_x", mul_x, 32'h0);
      chk("rst_mul_y", mul_y, 32'h0);
      chk("rst_out_valid", out_valid, 1'b0);
      chk("rst_out_data", out_data, 32'h0);
      chk("rst_out_tag", out_tag, 37'h0);
      reset = 1'b0;
      step();

      do_op("mulw",   2'b00, 32'h00000003, 32'hFFFFFFFE, 37'h12_3456_789A, 32'hFFFFFFFA, 1'b0);
      do_op("mulhw",  2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 37'h1, 32'h00000000, 1'b1);
      do_op("mulhwu", 2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 37'h2, 32'hFFFFFFFE, 1'b0);
      do_op("mulhmin",2'b01, 32'h80000000, 32'h80000000, 37'h3, 32'h40000000, 1'b1);
      do_op("rsv",    2'b11, 32'h00010000, 32'h00010003, 37'h4, 32'h00030000, 1'b0);

      // Back-pressure in DONE, then same-cycle hand-over to the next op.
      out_ready = 1'b0;
      present(2'b00, 32'd5, 32'd9, 37'h0A);
      accept_now("bp_acc");
      step(); step();
      present(2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 37'h0B);
      for (int i = 0; i < 5; i++) begin
         chk("bp_vld", out_valid, 1'b1);
         chk("bp_data", out_data, 32'd45);
         chk("bp_tag", out_tag, 37'h0A);
         chk("bp_in_ready", in_ready, 1'b0);
         step();
      end
      out_ready = 1'b1;
      #1;
      chk("bp_handover_ready", in_ready, 1'b1);
      step();
      in_valid = 1'b0;
      #1;
      chk("bp_next_mul", mul, 1'b1);
      chk("bp_next_nov", out_valid, 1'b0);
      step(); step();
      chk("bp_next_vld", out_valid, 1'b1);
      chk("bp_next_data", out_data, 32'hFFFFFFFE);
      chk("bp_next_tag", out_tag, 37'h0B);
      step();

      // Flush in BUSY0: one DRAIN cycle, then a clean 7*6.
      present(2'b00, 32'd100, 32'd100, 37'h0C);
      accept_now("f0_acc");
      flush = 1'b1;
      step();
      flush = 1'b0;
      #1;
      chk("f0_drain_mul", mul, 1'b1);
      chk("f0_drain_nov", out_valid, 1'b0);
      chk("f0_drain_rdy", in_ready, 1'b0);
      step();
      chk("f0_idle_mul", mul, 1'b0);
      chk("f0_idle_nov", out_valid, 1'b0);
      do_op("after_drain", 2'b00, 32'd7, 32'd6, 37'h0D, 32'd42, 1'b0);

      // Flush in BUSY1: product discarded, back to IDLE.
      present(2'b00, 32'd11, 32'd11, 37'h0E);
      accept_now("f1_acc");
      step();
      flush = 1'b1;
      step();
      flush = 1'b0;
      #1;
      chk("f1_nov", out_valid, 1'b0);
      chk("f1_mul", mul, 1'b0);
      chk("f1_idle_rdy", in_ready, 1'b1);

      // Flush in DONE: out_valid drops next cycle, no accept.
      out_ready = 1'b0;
      present(2'b00, 32'd2, 32'd3, 37'h0F);
      accept_now("fd_acc");
      step(); step();
      chk("fd_vld", out_valid, 1'b1);
      in_valid = 1'b1; out_ready = 1'b1; flush = 1'b1;
      #1;
      chk("fd_rdy", in_ready, 1'b0);
      step();
      flush = 1'b0; in_valid = 1'b0;
      #1;
      chk("fd_nov", out_valid, 1'b0);
      chk("fd_mul", mul, 1'b0);

      // Flush with in_valid in IDLE: no accept.
      present(2'b00, 32'd1, 32'd1, 37'h10);
      flush = 1'b1;
      #1;
      chk("fi_rdy", in_ready, 1'b0);
      step();
      flush = 1'b0; in_valid = 1'b0;
      #1;
      chk("fi_mul", mul, 1'b0);

      // Reset in BUSY1, then a normal op.
      present(2'b01, 32'h12345678, 32'h9ABCDEF0, 37'h11);
      accept_now("r_acc");
      step();
      reset = 1'b1;
      step();
      reset = 1'b0;
      #1;
      chk("r_mul", mul, 1'b0);
      chk("r_sgn", mul_signed, 1'b0);
      chk("r_x", mul_x, 32'h0);
      chk("r_vld", out_valid, 1'b0);
      chk("r_data", out_data, 32'h0);
      do_op("after_rst", 2'b00, 32'd1000, 32'd1000, 37'h12, 32'd1000000, 1'b0);

      // Randomized traffic against the reference.
      for (int c = 0; c < 4000; c++) begin
         step();
         reset     = ($urandom_range(0, 299) == 0);
         flush     = ($urandom_range(0, 15) == 0);
         out_ready = ($urandom_range(0, 9) < 7);
         in_valid  = ($urandom_range(0, 9) < 6);
         in_op     = 2'($urandom_range(0, 3));
         in_x      = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
         in_y      = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
         in_tag    = {5'($urandom), 32'($urandom)};
      end
      step();
      chk_en = 1'b0;

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mul_issue_ctrl.md
Name: mul_issue_ctrl

Overview:
- EXE-stage sequencer upstream of the Booth/Wallace multiplier. Accepts one multiply op at a time from the ID/EXE pipeline.
- Drives the multiplier's request, operand and signedness inputs and holds them stable until completion.
- Captures the 64-bit product and selects the 32-bit architectural result (mul.w / mulh.w / mulh.wu).
- Presents the result to the MEM stage through a valid/ready handshake, and handles pipeline flush so the multiplier's internal cycle counter is never left mid-count.

Parameters:
- TAG_W, 37, width of opaque pass-through tag (dest reg + PC bits), returned unchanged with the result.

Ports:
- mul_clk  in  1  clock; shared with the multiplier.
- reset  in  1  synchronous, active-high; also resets the multiplier.
- in_valid  in  1  op available from ID/EXE.
- in_ready  out  1  op accepted this cycle when in_valid & in_ready.
- in_op  in  2  00 MUL_W, 01 MULH_W, 10 MULH_WU, 11 reserved (treated as MUL_W).
- in_x  in  32  rj operand.
- in_y  in  32  rk operand.
- in_tag  in  TAG_W  pass-through tag.
- flush  in  1  exception/ertn cancel; kills the in-flight op.
- mul  out  1  multiplier request; held high while waiting.
- mul_signed  out  1  1 only for MULH_W.
- mul_x  out  32  registered operand.
- mul_y  out  32  registered operand.
- mul_result  in  64  product; valid only in a cycle where mul_complete=1.
- mul_complete  in  1  completion strobe from multiplier.
- out_valid  out  1  result available to MEM.
- out_ready  in  1  MEM accepts.
- out_data  out  32  selected result.
- out_tag  out  TAG_W  tag of the op.

Behaviour:
- Multiplier contract:
  - Its counter advances on every mul_clk edge where mul=1.
  - mul_complete asserts in the 2nd consecutive mul-high cycle, then the counter returns to 0.
  - Dropping mul freezes the counter. The controller must therefore always end a request on a complete cycle.
- States: IDLE, BUSY0, BUSY1, DONE, DRAIN (encoded in 3 bits).
- IDLE:
  - in_ready = ~flush.
  - On accept: register x, y, op, tag; go to BUSY0.
- BUSY0:
  - mul=1.
  - No flush: go to BUSY1.
  - flush: go to DRAIN (the counter has advanced to 1 and must be completed).
- BUSY1:
  - mul=1; mul_complete is expected.
  - On mul_complete: out_data <= MUL_W ? result[31:0] : result[63:32]; out_tag <= tag; go to DONE.
  - flush in the same cycle: discard the result and go to IDLE (the counter has already returned to 0).
  - If mul_complete is absent, stay in BUSY1 with mul held.
- DONE:
  - out_valid=1; out_data and out_tag are stable while out_ready=0.
  - in_ready = out_ready & ~flush.
  - On out_ready: accept a new op if in_valid (go to BUSY0), else go to IDLE.
  - flush: out_valid drops next cycle; go to IDLE; no accept.
- DRAIN:
  - mul=1, and mul_complete is expected.
  - The product is discarded and out_valid stays 0.
  - Go to IDLE on mul_complete.
  - flush and in_valid are ignored; in_ready=0.
- Outputs:
  - mul is high only in BUSY0, BUSY1 and DRAIN.
  - mul_x, mul_y and mul_signed change only on accept.
  - out_valid is high only in DONE.
- Latency:
  - Accept at cycle N; mul high in N+1 and N+2; out_valid from N+3.
  - Throughput is one op per 3 cycles with out_ready tied high.
- Flush priority: flush beats in_valid acceptance in the same cycle.
- Reset values:
  - state=IDLE.
  - mul=0, mul_signed=0, mul_x=0, mul_y=0.
  - out_valid=0, out_data=0, out_tag=0.
  - Reset mid-op returns to IDLE in one cycle (the multiplier counter also resets), with no drain.
- Errors:
  - mul_complete outside BUSY1/DRAIN is ignored.
  - Verification flags it as an assertion failure.

Decomposition:
- Shared package:
  - op encodings MUL_OP_W, MUL_OP_H, MUL_OP_HU;
  - state encodings;
  - the result-select function (op, 64-bit product → 32-bit result).
- No sub-module is needed. The multiplier is instantiated by the EXE stage next to this block and connected through the mul_* ports.

Test Plan:
- MUL_W, x=0x00000003, y=0xFFFFFFFE:
  - mul_signed=0; mul high for exactly 2 cycles;
  - out_valid at accept+3 with out_data=0xFFFFFFFA and tag echoed.
- x=y=0xFFFFFFFF:
  - MULH_W → out_data=0x00000000 (mul_signed=1);
  - MULH_WU → out_data=0xFFFFFFFE;
  - x=y=0x80000000 MULH_W → 0x40000000.
- Back-pressure:
  - out_ready=0 for 5 cycles in DONE: out_data/out_tag stable, in_ready=0.
  - Then out_ready=1 with in_valid=1: the next op is accepted the same cycle, and its result arrives 3 cycles later.
- flush in BUSY0:
  - DRAIN for one cycle with mul=1 and no out_valid.
  - The following MUL_W 7×6 returns exactly 42, proving the counter was re-aligned and no stale product leaked.
- flush in BUSY1, and flush in DONE:
  - No out_valid (BUSY1 case), or out_valid drops next cycle (DONE case); state returns to IDLE.
  - flush together with in_valid in IDLE: no accept.
- reset asserted in BUSY1: next cycle all outputs at reset values; a subsequent op completes normally.
